// File: rtl/ldm_sequencer_pkg.sv
// Shared definitions for the load-multiple sequencer: FSM encoding,
// addressing-mode codes ({P,U}) and the start-address helper.
package ldm_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam logic [1:0] MODE_DA = 2'b00;
  localparam logic [1:0] MODE_IA = 2'b01;
  localparam logic [1:0] MODE_DB = 2'b10;
  localparam logic [1:0] MODE_IB = 2'b11;

  localparam logic [3:0] R15_IDX = 4'd15;

  // Lowest word address of the block; transfers always walk upward from here.
  function automatic logic [31:0] start_addr(input logic [1:0] mode,
                                             input logic [31:0] base,
                                             input logic [4:0] n);
    logic [31:0] span;
    span = {25'd0, n, 2'b00};
    case (mode)
      MODE_IA: start_addr = base;
      MODE_IB: start_addr = base + 32'd4;
      MODE_DA: start_addr = base - span + 32'd4;
      default: start_addr = base - span;
    endcase
  endfunction

endpackage

// File: rtl/ldm_sequencer_reglist_scan.sv
// Combinational register-list scanner: lowest set index, list with that
// bit removed, and population count.
module reglist_scan (
  input  logic [15:0] list,
  output logic [3:0]  low_idx,
  output logic [15:0] rem,
  output logic [4:0]  count
);

  always_comb begin
    low_idx = 4'd0;
    count   = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (list[i]) low_idx = 4'(i);
    end
    for (int i = 0; i < 16; i++) begin
      count = count + {4'd0, list[i]};
    end
  end

  assign rem = list & (list - 16'd1);

endmodule

// File: rtl/ldm_sequencer.sv
// Load-multiple sequencer: walks a 16-bit register list, issues one word read
// per register and writes results (or PC) plus optional base writeback.
module ldm_sequencer
  import ldm_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] reglist,
  input  logic [3:0]  rn,
  input  logic [31:0] base,
  input  logic        pre,
  input  logic        up,
  input  logic        wback,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        we3,
  output logic [3:0]  wa3,
  output logic [31:0] wd3,
  output logic        we0,
  output logic [3:0]  wa0,
  output logic [31:0] wd0,
  output logic        pc_we,
  output logic [31:0] pc_wd,
  output logic        busy,
  output logic        done
);

  state_e      state_q, state_d;
  logic [15:0] list_q, list_d;
  logic [3:0]  rn_q, rn_d;
  logic        wb_en_q, wb_en_d;
  logic [31:0] wb_val_q, wb_val_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        we3_q, we3_d, we0_q, we0_d, pc_we_q, pc_we_d;
  logic [3:0]  wa3_q, wa3_d, wa0_q, wa0_d;
  logic [31:0] wd3_q, wd3_d, wd0_q, wd0_d, pc_wd_q, pc_wd_d;
  logic        busy_q, busy_d, done_q, done_d;

  // In IDLE the scanner counts the incoming list; otherwise it walks the remainder.
  logic [15:0] scan_list, scan_rem;
  logic [3:0]  scan_low;
  logic [4:0]  scan_cnt;
  logic [31:0] span;

  assign scan_list = (state_q == ST_IDLE) ? reglist : list_q;
  assign span      = {25'd0, scan_cnt, 2'b00};

  reglist_scan u_scan (
    .list    (scan_list),
    .low_idx (scan_low),
    .rem     (scan_rem),
    .count   (scan_cnt)
  );

  always_comb begin
    state_d    = state_q;
    list_d     = list_q;
    rn_d       = rn_q;
    wb_en_d    = wb_en_q;
    wb_val_d   = wb_val_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    we3_d      = 1'b0;
    wa3_d      = wa3_q;
    wd3_d      = wd3_q;
    we0_d      = 1'b0;
    wa0_d      = wa0_q;
    wd0_d      = wd0_q;
    pc_we_d    = 1'b0;
    pc_wd_d    = pc_wd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          list_d   = reglist;
          rn_d     = rn;
          wb_en_d  = wback & ~reglist[rn];
          wb_val_d = up ? base + span : base - span;
          busy_d   = 1'b1;
          if (scan_cnt != 5'd0) begin
            state_d    = ST_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = start_addr({pre, up}, base, scan_cnt);
          end else begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (mem_rvalid) begin
          state_d   = ST_WRITE;
          mem_req_d = 1'b0;
          list_d    = scan_rem;
          if (scan_low == R15_IDX) begin
            pc_we_d = 1'b1;
            pc_wd_d = {mem_rdata[31:2], 2'b00};
          end else begin
            we3_d = 1'b1;
            wa3_d = scan_low;
            wd3_d = mem_rdata;
          end
          // Writeback lands in the same cycle as the final register write.
          if (scan_rem == 16'd0 && wb_en_q) begin
            we0_d = 1'b1;
            wa0_d = rn_q;
            wd0_d = wb_val_q;
          end
        end
      end
      ST_WRITE: begin
        if (list_q != 16'd0) begin
          state_d    = ST_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = mem_addr_q + 32'd4;
        end else begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      list_q     <= '0;
      rn_q       <= '0;
      wb_en_q    <= 1'b0;
      wb_val_q   <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      we3_q      <= 1'b0;
      wa3_q      <= '0;
      wd3_q      <= '0;
      we0_q      <= 1'b0;
      wa0_q      <= '0;
      wd0_q      <= '0;
      pc_we_q    <= 1'b0;
      pc_wd_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      list_q     <= list_d;
      rn_q       <= rn_d;
      wb_en_q    <= wb_en_d;
      wb_val_q   <= wb_val_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      we3_q      <= we3_d;
      wa3_q      <= wa3_d;
      wd3_q      <= wd3_d;
      we0_q      <= we0_d;
      wa0_q      <= wa0_d;
      wd0_q      <= wd0_d;
      pc_we_q    <= pc_we_d;
      pc_wd_q    <= pc_wd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign we3      = we3_q;
  assign wa3      = wa3_q;
  assign wd3      = wd3_q;
  assign we0      = we0_q;
  assign wa0      = wa0_q;
  assign wd0      = wd0_q;
  assign pc_we    = pc_we_q;
  assign pc_wd    = pc_wd_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ldm_sequencer.sv
// Directed bench for ldm_sequencer with a latency-programmable memory model.
module tb_ldm_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, pre, up, wback;
  logic [15:0] reglist;
  logic [3:0]  rn;
  logic [31:0] base;
  logic        mem_req, mem_rvalid, we3, we0, pc_we, busy, done;
  logic [31:0] mem_addr, mem_rdata, wd3, wd0, pc_wd;
  logic [3:0]  wa3, wa0;

  int n_checks = 0;
  int n_errors = 0;

  // Memory model: data = addr ^ A5A50000 unless overridden; rvalid after lat waits.
  int          lat = 0;
  int          wcnt = 0;
  logic        stray = 1'b0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_addr = '0, ovr_data = '0;

  assign mem_rvalid = (mem_req && wcnt == lat) || stray;
  assign mem_rdata  = (ovr_en && mem_addr == ovr_addr) ? ovr_data : (mem_addr ^ 32'hA5A5_0000);

  always @(posedge clk) begin
    if (!mem_req || mem_rvalid) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  always #5 clk = ~clk;

  ldm_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .reglist(reglist), .rn(rn),
    .base(base), .pre(pre), .up(up), .wback(wback),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .we3(we3), .wa3(wa3), .wd3(wd3), .we0(we0), .wa0(wa0), .wd0(wd0),
    .pc_we(pc_we), .pc_wd(pc_wd), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Per-run observation logs
  logic [3:0]  w3_a[$];
  logic [31:0] w3_d[$];
  int          w3_c[$];
  logic [3:0]  w0_a[$];
  logic [31:0] w0_d[$];
  int          w0_c[$];
  logic [31:0] pc_d[$];
  int          pc_c[$];
  logic [31:0] rd_a[$];
  int          done_cyc, n_done, unstable, conflict;
  logic        busy_c0, busy_c1;
  logic [31:0] post_rst;

  function automatic logic [31:0] qa(input logic [3:0] q[$], input int i);
    qa = (i < q.size()) ? {28'd0, q[i]} : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] qd(input logic [31:0] q[$], input int i);
    qd = (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] qc(input int q[$], input int i);
    qc = (i < q.size()) ? q[i] : 32'hffff_ffff;
  endfunction

  // Cycle 0 is the cycle in which start is driven; runs a fixed number of cycles.
  task automatic run_cmd(input logic [15:0] l, input logic [3:0] r, input logic [31:0] b,
                         input logic p, input logic u, input logic w, input int lt,
                         input int rst_at, input int bsy_start_at, input int ncyc);
    logic        prev_wait;
    logic [31:0] prev_addr;
    w3_a.delete(); w3_d.delete(); w3_c.delete();
    w0_a.delete(); w0_d.delete(); w0_c.delete();
    pc_d.delete(); pc_c.delete(); rd_a.delete();
    done_cyc = -1; n_done = 0; unstable = 0; conflict = 0;
    busy_c0 = 1'bx; busy_c1 = 1'bx; post_rst = 32'hxxxx_xxxx;
    prev_wait = 1'b0; prev_addr = '0;
    lat = lt;
    @(posedge clk); #1;
    start = 1'b1; reglist = l; rn = r; base = b; pre = p; up = u; wback = w;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == 0) busy_c0 = busy;
      if (c == 1) busy_c1 = busy;
      if (we3) begin w3_a.push_back(wa3); w3_d.push_back(wd3); w3_c.push_back(c); end
      if (we0) begin w0_a.push_back(wa0); w0_d.push_back(wd0); w0_c.push_back(c); end
      if (pc_we) begin pc_d.push_back(pc_wd); pc_c.push_back(c); end
      if (mem_req && mem_rvalid) rd_a.push_back(mem_addr);
      if (done) begin
        if (done_cyc < 0) done_cyc = c;
        n_done++;
      end
      if (mem_req && prev_wait && mem_addr !== prev_addr) unstable++;
      if (we3 && we0 && wa3 == wa0) conflict++;
      if (rst_at >= 0 && c == rst_at + 1)
        post_rst = {26'd0, mem_req, we3, we0, pc_we, busy, done} |
                   mem_addr | {28'd0, wa3} | wd3 | {28'd0, wa0} | wd0 | pc_wd;
      prev_wait = mem_req && !mem_rvalid;
      prev_addr = mem_addr;
      @(posedge clk); #1;
      start = (c + 1 == bsy_start_at);
      if (start) begin
        reglist = 16'hFFFF; rn = 4'd7; base = 32'h0000_9000; pre = 1'b1; up = 1'b0; wback = 1'b1;
      end
      reset = (c + 1 == rst_at);
    end
    start = 1'b0;
  endtask

  task automatic check_ia_1000(input string t);
    check({t, "_n_w3"}, w3_a.size(), 3);
    check({t, "_w3a0"}, qa(w3_a, 0), 1);
    check({t, "_w3d0"}, qd(w3_d, 0), 32'hA5A5_1000);
    check({t, "_w3c0"}, qc(w3_c, 0), 2);
    check({t, "_w3a1"}, qa(w3_a, 1), 2);
    check({t, "_w3d1"}, qd(w3_d, 1), 32'hA5A5_1004);
    check({t, "_w3c1"}, qc(w3_c, 1), 4);
    check({t, "_w3a2"}, qa(w3_a, 2), 3);
    check({t, "_w3d2"}, qd(w3_d, 2), 32'hA5A5_1008);
    check({t, "_w3c2"}, qc(w3_c, 2), 6);
    check({t, "_n_w0"}, w0_a.size(), 1);
    check({t, "_w0a"}, qa(w0_a, 0), 0);
    check({t, "_w0d"}, qd(w0_d, 0), 32'h0000_100C);
    check({t, "_w0c"}, qc(w0_c, 0), 6);
    check({t, "_rd0"}, qd(rd_a, 0), 32'h0000_1000);
    check({t, "_rd1"}, qd(rd_a, 1), 32'h0000_1004);
    check({t, "_rd2"}, qd(rd_a, 2), 32'h0000_1008);
    check({t, "_done_cyc"}, done_cyc, 7);
    check({t, "_n_done"}, n_done, 1);
    check({t, "_busy_c0"}, {31'd0, busy_c0}, 0);
    check({t, "_busy_c1"}, {31'd0, busy_c1}, 1);
    check({t, "_pc_we"}, pc_d.size(), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; reglist = 16'h00FF; rn = 4'd0; base = 32'h1000;
    pre = 1'b0; up = 1'b1; wback = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {26'd0, mem_req, we3, we0, pc_we, busy, done}, 0);
    check("rst_data", mem_addr | {28'd0, wa3} | wd3 | {28'd0, wa0} | wd0 | pc_wd, 0);
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_ignored", {30'd0, busy, mem_req}, 0);

    // Stray rvalid while idle has no effect
    @(posedge clk); #1; stray = 1'b1;
    @(posedge clk); #1; stray = 1'b0;
    @(negedge clk);
    check("stray_rvalid", {29'd0, we3, pc_we, busy}, 0);

    run_cmd(16'h000E, 4'd0, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 0, -1, -1, 12);
    check_ia_1000("ia");
    check("ia_conflict", conflict, 0);

    run_cmd(16'h0005, 4'd13, 32'h0000_2000, 1'b1, 1'b0, 1'b1, 0, -1, -1, 10);
    check("db_n_w3", w3_a.size(), 2);
    check("db_w3a0", qa(w3_a, 0), 0);
    check("db_w3d0", qd(w3_d, 0), 32'hA5A5_1FF8);
    check("db_w3a1", qa(w3_a, 1), 2);
    check("db_w3d1", qd(w3_d, 1), 32'hA5A5_1FFC);
    check("db_w0a", qa(w0_a, 0), 13);
    check("db_w0d", qd(w0_d, 0), 32'h0000_1FF8);
    check("db_w0c", qc(w0_c, 0), 4);
    check("db_done_cyc", done_cyc, 5);

    run_cmd(16'h0011, 4'd5, 32'h0000_7000, 1'b1, 1'b1, 1'b1, 0, -1, -1, 10);
    check("ib_rd0", qd(rd_a, 0), 32'h0000_7004);
    check("ib_rd1", qd(rd_a, 1), 32'h0000_7008);
    check("ib_w3a1", qa(w3_a, 1), 4);
    check("ib_w0d", qd(w0_d, 0), 32'h0000_7008);

    run_cmd(16'h0006, 4'd0, 32'h0000_8000, 1'b0, 1'b0, 1'b1, 0, -1, -1, 10);
    check("da_rd0", qd(rd_a, 0), 32'h0000_7FFC);
    check("da_w3a0", qa(w3_a, 0), 1);
    check("da_w3d1", qd(w3_d, 1), 32'hA5A5_8000);
    check("da_w0d", qd(w0_d, 0), 32'h0000_7FF8);

    ovr_en = 1'b1; ovr_addr = 32'h0000_3004; ovr_data = 32'h0040_0003;
    run_cmd(16'h8001, 4'd2, 32'h0000_3000, 1'b0, 1'b1, 1'b0, 0, -1, -1, 10);
    ovr_en = 1'b0;
    check("r15_n_w3", w3_a.size(), 1);
    check("r15_w3a0", qa(w3_a, 0), 0);
    check("r15_n_pc", pc_d.size(), 1);
    check("r15_pc_wd", qd(pc_d, 0), 32'h0040_0000);
    check("r15_pc_c", qc(pc_c, 0), 4);
    check("r15_n_w0", w0_a.size(), 0);

    run_cmd(16'h0002, 4'd1, 32'h0000_4000, 1'b0, 1'b1, 1'b1, 0, -1, -1, 8);
    check("inlist_w3a", qa(w3_a, 0), 1);
    check("inlist_w3d", qd(w3_d, 0), 32'hA5A5_4000);
    check("inlist_n_w0", w0_a.size(), 0);
    check("inlist_done", done_cyc, 3);

    run_cmd(16'h0000, 4'd3, 32'h0000_6000, 1'b0, 1'b1, 1'b1, 0, -1, -1, 6);
    check("empty_done_cyc", done_cyc, 1);
    check("empty_n_done", n_done, 1);
    check("empty_n_rd", rd_a.size(), 0);
    check("empty_writes", w3_a.size() + w0_a.size() + pc_d.size(), 0);

    // 3-cycle read latency, reset raised during the second REQ
    run_cmd(16'h0003, 4'd4, 32'h0000_5000, 1'b0, 1'b1, 1'b1, 3, 7, -1, 16);
    check("dly_n_w3", w3_a.size(), 1);
    check("dly_w3c0", qc(w3_c, 0), 5);
    check("dly_w3d0", qd(w3_d, 0), 32'hA5A5_5000);
    check("dly_addr_stable", unstable, 0);
    check("dly_post_rst", post_rst, 0);
    check("dly_no_done", done_cyc, 32'hFFFF_FFFF);
    check("dly_n_w0", w0_a.size(), 0);

    run_cmd(16'h000E, 4'd0, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 0, -1, 3, 14);
    check_ia_1000("busy_start");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
